// File: rtl/ddr3_cmd_fsm.sv
// ddr3_cmd_fsm: closed-page DDR3 command sequencer.
// Each upstream request runs ACT -> RD/WR -> PRE and then returns to IDLE.
// Periodic refresh is present only when the macro DDR3_CMD_REFRESH_EN is defined.
// In the default build there is no refresh logic, and REF is never issued.
// All DDR command and response outputs are registered.
// mem_accept_o is decoded from the state register.
module ddr3_cmd_fsm #(
    parameter int unsigned TRCD       = 6,
    parameter int unsigned TRP        = 6,
    parameter int unsigned TRAS       = 15,
    parameter int unsigned TWR        = 8,
    parameter int unsigned TRFC       = 44,
    parameter int unsigned TREFI      = 780,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_store_i,
    input  logic        mem_fetch_i,
    input  logic [3:0]  mem_req_id_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_wrmask_i,
    input  logic [31:0] mem_wrdata_i,
    output logic        mem_accept_o,
    output logic        mem_valid_o,
    output logic        mem_error_o,
    output logic [3:0]  mem_resp_id_o,
    output logic [31:0] mem_rddata_o,
    output logic [2:0]  cmd_o,
    output logic [2:0]  cmd_bank_o,
    output logic [13:0] cmd_addr_o,
    output logic [3:0]  cmd_wrmask_o,
    output logic [31:0] cmd_wrdata_o,
    input  logic        rd_valid_i,
    input  logic [31:0] rd_data_i
);

    typedef enum logic [2:0] {
        IDLE, ACT_WAIT, ACCESS, RD_WAIT, WR_REC, PRE_WAIT, REF_WAIT
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2,
        CMD_WR  = 3'd3, CMD_PRE = 3'd4, CMD_REF = 3'd5
    } cmd_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One shared per-state phase counter covers every wait except tRAS.
    localparam int unsigned PH_MAX = max2(max2(max2(TRCD, TWR), max2(RD_TIMEOUT, TRP)), TRFC);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned RAS_W  = $clog2(TRAS + 1);

    // A command is loaded one cycle before it appears on cmd_o.
    // Each *_LAST value is therefore the phase at which the next command is loaded.
    localparam logic [PH_W-1:0]  RCD_LAST = PH_W'((TRCD >= 1) ? TRCD - 1 : 0);
    localparam logic [PH_W-1:0]  WR_LAST  = PH_W'((TWR >= 2) ? TWR - 2 : 0);
    localparam logic [PH_W-1:0]  TO_LAST  = PH_W'((RD_TIMEOUT >= 1) ? RD_TIMEOUT - 1 : 0);
    localparam logic [PH_W-1:0]  TRP_LAST = PH_W'(TRP);
    localparam logic [RAS_W-1:0] RAS_LAST = RAS_W'((TRAS >= 1) ? TRAS - 1 : 0);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_cnt;
    logic [RAS_W-1:0]  ras_cnt;
    logic              ready_q;
    logic              refresh_req;
    logic              take;

    // Request fields captured on the accepting cycle.
    logic              wr_q, bad_q;
    logic [3:0]        id_q;
    logic [2:0]        bank_q;
    logic [9:0]        col_q;
    logic [3:0]        mask_q;
    logic [31:0]       data_q;

    cmd_e              cmd_d;
    logic [2:0]        cmd_bank_d;
    logic [13:0]       cmd_addr_d;
    logic [3:0]        cmd_wrmask_d;
    logic [31:0]       cmd_wrdata_d;
    logic              valid_d, error_d;
    logic [3:0]        resp_id_d;
    logic [31:0]       rddata_d;

    // Address bits outside the row/bank/column fields are not used.
    logic              unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_addr_i[31:29], mem_addr_i[1:0]};

`ifdef DDR3_CMD_REFRESH_EN
    localparam int unsigned       REFI_W    = $clog2(TREFI + 1);
    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'((TREFI >= 1) ? TREFI - 1 : 0);
    localparam logic [PH_W-1:0]   RFC_LAST  = PH_W'((TRFC >= 1) ? TRFC - 1 : 0);

    logic [REFI_W-1:0] refi_cnt;
    logic              refi_wrap;
    logic              ref_pend_q;
    logic              ref_clear;

    // A refresh wins over a request in the same cycle as the counter wrap.
    // It also wins in any later IDLE cycle while the refresh is pending.
    assign refi_wrap   = (refi_cnt == REFI_LAST);
    assign refresh_req = ref_pend_q | refi_wrap;

    // Free-running refresh interval counter with a single, non-queueing pending flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refi_cnt   <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            refi_cnt <= refi_wrap ? '0 : refi_cnt + REFI_W'(1);
            if (refi_wrap)
                ref_pend_q <= 1'b1;
            else if (ref_clear)
                ref_pend_q <= 1'b0;
        end
    end
`else
    // TREFI has no effect without refresh support.
    assign refresh_req = (TREFI == 0) && 1'b0;
`endif

    assign mem_accept_o = ready_q && (state_q == IDLE) && !refresh_req;
    assign take         = mem_accept_o && (mem_store_i || mem_fetch_i);

    // Compute the next state and the next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        cmd_d        = CMD_NOP;
        cmd_bank_d   = '0;
        cmd_addr_d   = '0;
        cmd_wrmask_d = '0;
        cmd_wrdata_d = '0;
        valid_d      = 1'b0;
        error_d      = 1'b0;
        resp_id_d    = mem_resp_id_o;
        rddata_d     = mem_rddata_o;
`ifdef DDR3_CMD_REFRESH_EN
        ref_clear    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef DDR3_CMD_REFRESH_EN
                if (ready_q && refresh_req) begin
                    cmd_d   = CMD_REF;
                    state_d = REF_WAIT;
                end else
`endif
                if (take) begin
                    if (mem_store_i && mem_fetch_i) begin
                        // A conflicting request issues no DDR command.
                        // It spends one cycle in ACCESS so that accept stays low during the error response.
                        valid_d   = 1'b1;
                        error_d   = 1'b1;
                        resp_id_d = mem_req_id_i;
                        state_d   = ACCESS;
                    end else begin
                        cmd_d      = CMD_ACT;
                        cmd_bank_d = mem_addr_i[14:12];
                        cmd_addr_d = mem_addr_i[28:15];
                        state_d    = ACT_WAIT;
                    end
                end
            end
            ACT_WAIT: begin
                if (phase_cnt >= RCD_LAST) begin
                    cmd_d      = wr_q ? CMD_WR : CMD_RD;
                    cmd_bank_d = bank_q;
                    cmd_addr_d = {4'b0, col_q};
                    if (wr_q) begin
                        cmd_wrmask_d = mask_q;
                        cmd_wrdata_d = data_q;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bad_q) begin
                    state_d = IDLE;
                end else if (wr_q) begin
                    valid_d   = 1'b1;
                    resp_id_d = id_q;
                    state_d   = WR_REC;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_valid_i) begin
                    valid_d   = 1'b1;
                    resp_id_d = id_q;
                    rddata_d  = rd_data_i;
                    state_d   = WR_REC;
                end else if (phase_cnt >= TO_LAST) begin
                    valid_d   = 1'b1;
                    error_d   = 1'b1;
                    resp_id_d = id_q;
                    rddata_d  = '0;
                    state_d   = WR_REC;
                end
            end
            WR_REC: begin
                // Reads also pass through this state so that PRE waits for tRAS.
                // For reads, the tWR term does not apply.
                if ((!wr_q || phase_cnt >= WR_LAST) && ras_cnt >= RAS_LAST) begin
                    cmd_d      = CMD_PRE;
                    cmd_bank_d = bank_q;
                    state_d    = PRE_WAIT;
                end
            end
            PRE_WAIT: begin
                if (phase_cnt >= TRP_LAST)
                    state_d = IDLE;
            end
`ifdef DDR3_CMD_REFRESH_EN
            REF_WAIT: begin
                if (phase_cnt >= RFC_LAST) begin
                    ref_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Update the state, the saturating timers, the captured request and the registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            phase_cnt     <= '0;
            ras_cnt       <= '0;
            ready_q       <= 1'b0;
            wr_q          <= 1'b0;
            bad_q         <= 1'b0;
            id_q          <= '0;
            bank_q        <= '0;
            col_q         <= '0;
            mask_q        <= '0;
            data_q        <= '0;
            cmd_o         <= '0;
            cmd_bank_o    <= '0;
            cmd_addr_o    <= '0;
            cmd_wrmask_o  <= '0;
            cmd_wrdata_o  <= '0;
            mem_valid_o   <= 1'b0;
            mem_error_o   <= 1'b0;
            mem_resp_id_o <= '0;
            mem_rddata_o  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if (state_d != state_q)
                phase_cnt <= '0;
            else if (phase_cnt != '1)
                phase_cnt <= phase_cnt + PH_W'(1);
            if (cmd_d == CMD_ACT)
                ras_cnt <= '0;
            else if (ras_cnt != '1)
                ras_cnt <= ras_cnt + RAS_W'(1);
            if (take) begin
                wr_q   <= mem_store_i;
                bad_q  <= mem_store_i && mem_fetch_i;
                id_q   <= mem_req_id_i;
                bank_q <= mem_addr_i[14:12];
                col_q  <= mem_addr_i[11:2];
                mask_q <= mem_wrmask_i;
                data_q <= mem_wrdata_i;
            end
            cmd_o         <= cmd_d;
            cmd_bank_o    <= cmd_bank_d;
            cmd_addr_o    <= cmd_addr_d;
            cmd_wrmask_o  <= cmd_wrmask_d;
            cmd_wrdata_o  <= cmd_wrdata_d;
            mem_valid_o   <= valid_d;
            mem_error_o   <= error_d;
            mem_resp_id_o <= resp_id_d;
            mem_rddata_o  <= rddata_d;
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_fsm.sv
// tb_ddr3_cmd_fsm: directed-vector bench for ddr3_cmd_fsm.
// The bench traces the DUT cycle by cycle from the start of each request.
// It then compares the trace against hand-computed timing.
// Refresh checks follow the DDR3_CMD_REFRESH_EN macro.
module tb_ddr3_cmd_fsm;

    localparam int unsigned P_TRCD = 6, P_TRP = 6, P_TRAS = 15, P_TWR = 8;
    localparam int unsigned P_TRFC = 44, P_TREFI = 780, P_RD_TIMEOUT = 16;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_store_i, mem_fetch_i;
    logic [3:0]  mem_req_id_i, mem_wrmask_i;
    logic [31:0] mem_addr_i, mem_wrdata_i;
    logic        mem_accept_o, mem_valid_o, mem_error_o;
    logic [3:0]  mem_resp_id_o;
    logic [31:0] mem_rddata_o;
    logic [2:0]  cmd_o, cmd_bank_o;
    logic [13:0] cmd_addr_o;
    logic [3:0]  cmd_wrmask_o;
    logic [31:0] cmd_wrdata_o;
    logic        rd_valid_i;
    logic [31:0] rd_data_i;

    always #5 clock = ~clock;

    ddr3_cmd_fsm #(
        .TRCD(P_TRCD), .TRP(P_TRP), .TRAS(P_TRAS), .TWR(P_TWR),
        .TRFC(P_TRFC), .TREFI(P_TREFI), .RD_TIMEOUT(P_RD_TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_store_i(mem_store_i), .mem_fetch_i(mem_fetch_i),
        .mem_req_id_i(mem_req_id_i), .mem_addr_i(mem_addr_i),
        .mem_wrmask_i(mem_wrmask_i), .mem_wrdata_i(mem_wrdata_i),
        .mem_accept_o(mem_accept_o), .mem_valid_o(mem_valid_o),
        .mem_error_o(mem_error_o), .mem_resp_id_o(mem_resp_id_o),
        .mem_rddata_o(mem_rddata_o), .cmd_o(cmd_o), .cmd_bank_o(cmd_bank_o),
        .cmd_addr_o(cmd_addr_o), .cmd_wrmask_o(cmd_wrmask_o),
        .cmd_wrdata_o(cmd_wrdata_o), .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [2:0]  t_cmd   [0:79];
    logic [2:0]  t_bank  [0:79];
    logic [13:0] t_addr  [0:79];
    logic [3:0]  t_mask  [0:79];
    logic [31:0] t_wdata [0:79];
    logic        t_acc   [0:79];
    logic        t_val   [0:79];
    logic        t_err   [0:79];
    logic [3:0]  t_id    [0:79];
    logic [31:0] t_rdata [0:79];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Index 0 is the cycle the request is first presented; the request is held until accepted.
    // rd_valid_i pulses with real data at rdv_at and with junk at stray_at (-1 disables).
    task automatic run(input logic st, input logic fe, input logic [3:0] id,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wdata,
                       input int rdv_at, input logic [31:0] rdv_data, input int stray_at, input int n);
        logic want;
        want = st | fe;
        for (int i = 0; i < n; i++) begin
            mem_store_i  = want & st;
            mem_fetch_i  = want & fe;
            mem_req_id_i = id;
            mem_addr_i   = addr;
            mem_wrmask_i = mask;
            mem_wrdata_i = wdata;
            rd_valid_i   = (i == rdv_at) || (i == stray_at);
            rd_data_i    = (i == rdv_at) ? rdv_data : ((i == stray_at) ? 32'hBAD0_BAD0 : 32'h0);
            #1;
            t_cmd[i] = cmd_o;        t_bank[i] = cmd_bank_o;   t_addr[i] = cmd_addr_o;
            t_mask[i] = cmd_wrmask_o; t_wdata[i] = cmd_wrdata_o; t_acc[i] = mem_accept_o;
            t_val[i] = mem_valid_o;  t_err[i] = mem_error_o;   t_id[i] = mem_resp_id_o;
            t_rdata[i] = mem_rddata_o;
            if (mem_accept_o) want = 1'b0;
            @(posedge clock);
            #1;
        end
        mem_store_i = 1'b0;
        mem_fetch_i = 1'b0;
        rd_valid_i  = 1'b0;
        rd_data_i   = '0;
    endtask

    function automatic int cnt_nonnop(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (t_cmd[i] != NOP) c++;
        return c;
    endfunction

    function automatic int cnt_cmd(input int n, input logic [2:0] k);
        int c = 0;
        for (int i = 0; i < n; i++) if (t_cmd[i] == k) c++;
        return c;
    endfunction

    function automatic int cnt_valid(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (t_val[i]) c++;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        mem_store_i = 1'b0; mem_fetch_i = 1'b0; mem_req_id_i = '0; mem_addr_i = '0;
        mem_wrmask_i = '0; mem_wrdata_i = '0; rd_valid_i = 1'b0; rd_data_i = '0;

        // Values held during reset
        repeat (2) @(posedge clock);
        #1;
        check("rst_accept", mem_accept_o, 0);
        check("rst_valid", mem_valid_o, 0);
        check("rst_error", mem_error_o, 0);
        check("rst_cmd", cmd_o, NOP);
        check("rst_bank", cmd_bank_o, 0);
        check("rst_addr", cmd_addr_o, 0);
        check("rst_wrmask", cmd_wrmask_o, 0);
        check("rst_wrdata", cmd_wrdata_o, 0);
        check("rst_resp_id", mem_resp_id_o, 0);
        check("rst_rddata", mem_rddata_o, 0);
        reset = 1'b1;
        #1;
        check("acc_before_clk", mem_accept_o, 0);
        @(posedge clock);
        #1;
        check("acc_first_clk", mem_accept_o, 1);

        // Write: bank 3, row 2, col 0x292; a stray rd_valid_i in WR_REC is ignored
        run(1'b1, 1'b0, 4'd6, 32'h0001_3A48, 4'hA, 32'h1234_5678, -1, 32'h0, 10, 24);
        check("wr_accept", t_acc[0], 1);
        check("wr_act", t_cmd[1], ACT);
        check("wr_act_bank", t_bank[1], 3);
        check("wr_act_row", t_addr[1], 2);
        check("wr_nop6", t_cmd[6], NOP);
        check("wr_wr", t_cmd[7], WR);
        check("wr_col", t_addr[7], 14'h292);
        check("wr_bank", t_bank[7], 3);
        check("wr_mask", t_mask[7], 4'hA);
        check("wr_data", t_wdata[7], 32'h1234_5678);
        check("wr_valid", t_val[8], 1);
        check("wr_error", t_err[8], 0);
        check("wr_resp_id", t_id[8], 6);
        check("wr_pre_early", t_cmd[15], NOP);
        check("wr_pre", t_cmd[16], PRE);
        check("wr_pre_bank", t_bank[16], 3);
        check("wr_acc22", t_acc[22], 0);
        check("wr_acc23", t_acc[23], 1);
        check("wr_ncmd", cnt_nonnop(24), 3);
        check("wr_nvalid", cnt_valid(24), 1);

        // Read: data arrives at N+10; a stray strobe during ACT_WAIT is ignored
        run(1'b0, 1'b1, 4'd2, 32'h0, 4'h0, 32'h0, 10, 32'hDEAD_BEEF, 4, 24);
        check("rd_act", t_cmd[1], ACT);
        check("rd_rd", t_cmd[7], RD);
        check("rd_col", t_addr[7], 0);
        check("rd_valid", t_val[11], 1);
        check("rd_data", t_rdata[11], 32'hDEAD_BEEF);
        check("rd_resp_id", t_id[11], 2);
        check("rd_error", t_err[11], 0);
        check("rd_pre", t_cmd[16], PRE);
        check("rd_nvalid", cnt_valid(24), 1);
        check("rd_acc23", t_acc[23], 1);

        // Read timeout: the RD is at cycle 7 and the error response at 7+RD_TIMEOUT+1
        run(1'b0, 1'b1, 4'd9, 32'h0000_5004, 4'h0, 32'h0, -1, 32'h0, 30, 34);
        check("to_rd", t_cmd[7], RD);
        check("to_col", t_addr[7], 1);
        check("to_bank", t_bank[7], 5);
        check("to_no_early", t_val[23], 0);
        check("to_valid", t_val[24], 1);
        check("to_error", t_err[24], 1);
        check("to_rddata", t_rdata[24], 0);
        check("to_resp_id", t_id[24], 9);
        check("to_pre", t_cmd[25], PRE);
        check("to_pre_bank", t_bank[25], 5);
        check("to_acc31", t_acc[31], 0);
        check("to_acc32", t_acc[32], 1);
        check("to_nvalid", cnt_valid(34), 1);
        check("to_ncmd", cnt_nonnop(34), 3);

        // Store and fetch together
        run(1'b1, 1'b1, 4'hA, 32'h0001_3A48, 4'hF, 32'h0, -1, 32'h0, -1, 6);
        check("both_accept", t_acc[0], 1);
        check("both_valid", t_val[1], 1);
        check("both_error", t_err[1], 1);
        check("both_resp_id", t_id[1], 4'hA);
        check("both_acc1", t_acc[1], 0);
        check("both_acc2", t_acc[2], 1);
        check("both_ncmd", cnt_nonnop(6), 0);
        check("both_nvalid", cnt_valid(6), 1);

        // Reset asserted 3 cycles after ACT
        run(1'b1, 1'b0, 4'd3, 32'h0001_3A48, 4'hF, 32'h5555_AAAA, -1, 32'h0, -1, 4);
        check("mr_act", t_cmd[1], ACT);
        #2;
        reset = 1'b0;
        #1;
        check("mr_cmd", cmd_o, NOP);
        check("mr_bank", cmd_bank_o, 0);
        check("mr_addr", cmd_addr_o, 0);
        check("mr_accept", mem_accept_o, 0);
        check("mr_valid", mem_valid_o, 0);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        run(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, -1, 32'h0, -1, 30);
        check("mr_acc_after", t_acc[0], 1);
        check("mr_ncmd", cnt_nonnop(30), 0);
        check("mr_nvalid", cnt_valid(30), 0);

        // Request in the cycle the refresh interval expires (fresh reset restarts the interval)
        reset = 1'b0;
        #2;
        reset = 1'b1;
        repeat (P_TREFI - 1) @(posedge clock);
        #1;
`ifdef DDR3_CMD_REFRESH_EN
        run(1'b1, 1'b0, 4'd5, 32'h0001_3A48, 4'h3, 32'h0F0F_0F0F, -1, 32'h0, -1, 62);
        check("rf_acc0", t_acc[0], 0);
        check("rf_ref", t_cmd[1], REF);
        check("rf_acc44", t_acc[44], 0);
        check("rf_acc45", t_acc[45], 1);
        check("rf_act", t_cmd[46], ACT);
        check("rf_wr", t_cmd[52], WR);
        check("rf_valid", t_val[53], 1);
        check("rf_pre", t_cmd[61], PRE);
        check("rf_nref", cnt_cmd(62, REF), 1);
        check("rf_ncmd", cnt_nonnop(62), 4);
`else
        run(1'b1, 1'b0, 4'd5, 32'h0001_3A48, 4'h3, 32'h0F0F_0F0F, -1, 32'h0, -1, 24);
        check("nr_acc0", t_acc[0], 1);
        check("nr_act", t_cmd[1], ACT);
        check("nr_nref", cnt_cmd(24, REF), 0);
        begin
            int refs = 0;
            int accs = 0;
            for (int i = 0; i < 2 * int'(P_TREFI); i++) begin
                @(posedge clock);
                #1;
                if (cmd_o == REF) refs++;
                if (mem_accept_o) accs++;
            end
            check("nr_long_nref", refs, 0);
            check("nr_long_accept", accs, 2 * P_TREFI);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
